io_interrupt_unit: RTL and testbench

- Parametrised, multi-channel successor to the single FGI/FGO/IEN I/O logic of the team's basic-computer datapath.
- Each of CHANNELS channels has an input register (INPR) with input flag FGI, and an output register (OUTR) with output flag FGO.
- Contains the IEN flip-flop, a per-channel interrupt mask, and the interrupt flip-flop R with a fixed-priority vector.
- Sits between external devices (valid/ready handshakes) and the control unit (INP/OUT/SKI/SKO/ION/IOF and interrupt cycle).

---
 rtl/io_interrupt_unit.sv | 194 +++++++++++++++++++
 tb/tb_io_interrupt_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/io_interrupt_unit.sv
// ---------------------------------------------------------------------------
// io_interrupt_unit
//
// Multi-channel I/O and interrupt logic for the basic-computer control unit.
// Each channel owns an input register (INPR) with flag FGI and an output
// register (OUTR) with flag FGO. The block also holds the interrupt enable
// flip-flop (IEN), a per-channel interrupt mask and the interrupt flip-flop R
// together with a fixed-priority interrupt vector.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_data    device -> INPR handshake (in_ready = ~fgi)
//   out_valid/out_data  OUTR -> device handshake (out_valid = ~fgo)
//   out_ready           device accepts the OUTR character
//   cpu_ch/rd/wr/wdata  INP / OUT instructions addressing one channel
//   cpu_rdata           INPR of the addressed channel (combinational)
//   fgi, fgo            flags for SKI / SKO
//   wr_overrun          sticky per-channel flag: OUT issued while FGO=0
//   ien_set/ien_clr/ien ION / IOF and the IEN flip-flop
//   mask_wr/mask_wdata  interrupt mask load (1 = channel may interrupt)
//   fetch_idle          control unit outside T0..T2, R may be set
//   int_req/int_vec     R flip-flop and latched {channel, is_output}
//   int_ack             interrupt cycle complete (clears R and IEN)
// ---------------------------------------------------------------------------
module io_interrupt_unit #(
  parameter int CH_W     = 2,
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 2 ** CH_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          in_valid,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic [CHANNELS-1:0]          in_ready,
  output logic [CHANNELS-1:0]          out_valid,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  input  logic [CHANNELS-1:0]          out_ready,
  input  logic [CH_W-1:0]              cpu_ch,
  input  logic                         cpu_rd,
  input  logic                         cpu_wr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic [CHANNELS-1:0]          fgi,
  output logic [CHANNELS-1:0]          fgo,
  output logic [CHANNELS-1:0]          wr_overrun,
  input  logic                         ien_set,
  input  logic                         ien_clr,
  output logic                         ien,
  input  logic                         mask_wr,
  input  logic [CHANNELS-1:0]          mask_wdata,
  input  logic                         fetch_idle,
  output logic                         int_req,
  output logic [CH_W:0]                int_vec,
  input  logic                         int_ack
);

  localparam int PEND_W = 2 * CHANNELS;

  // Register state
  logic [CHANNELS-1:0][DATA_W-1:0] inpr_r;
  logic [CHANNELS-1:0][DATA_W-1:0] outr_r;
  logic [CHANNELS-1:0]             fgi_r;
  logic [CHANNELS-1:0]             fgo_r;
  logic [CHANNELS-1:0]             wr_overrun_r;
  logic [CHANNELS-1:0]             mask_r;
  logic                            ien_r;
  logic                            int_req_r;
  logic [CH_W:0]                   int_vec_r;

  // Combinational helpers
  logic [CHANNELS-1:0]             ch_sel_s;
  logic [PEND_W-1:0]               pend_s;
  logic [CH_W:0]                   win_s;
  logic                            r_set_s;

  // One-hot decode of the CPU-addressed channel.
  always_comb begin
    ch_sel_s         = {CHANNELS{1'b0}};
    ch_sel_s[cpu_ch] = 1'b1;
  end

  // Pending vector: even bit = input flag, odd bit = output flag, both masked.
  // The bit index therefore equals {channel, is_output}.
  always_comb begin
    pend_s = {PEND_W{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      pend_s[2*i]   = fgi_r[i] & mask_r[i];
      pend_s[2*i+1] = fgo_r[i] & mask_r[i];
    end
  end

  // Fixed-priority encoder: scanning downwards leaves the lowest set bit.
  always_comb begin
    win_s = {(CH_W+1){1'b0}};
    for (int k = PEND_W - 1; k >= 0; k--) begin
      if (pend_s[k]) begin
        win_s = k[CH_W:0];
      end else begin
        win_s = win_s;
      end
    end
  end

  // R may set only while idle, enabled and something is pending.
  assign r_set_s = ien_r & fetch_idle & (|pend_s) & ~int_req_r;

  // Input side: device capture into INPR and INP flag clear.
  // Capture needs fgi=0 and clear needs fgi=1, so they never collide.
  always_ff @(posedge clock) begin
    if (reset) begin
      inpr_r <= '0;
      fgi_r  <= {CHANNELS{1'b0}};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (in_valid[i] && !fgi_r[i]) begin
          inpr_r[i] <= in_data[i*DATA_W +: DATA_W];
          fgi_r[i]  <= 1'b1;
        end else if (cpu_rd && ch_sel_s[i] && fgi_r[i]) begin
          fgi_r[i]  <= 1'b0;
        end
      end
    end
  end

  // Output side: OUT load / overrun detection and device transfer.
  // OUT acts only with fgo=1 and transfer only with fgo=0: mutually exclusive.
  always_ff @(posedge clock) begin
    if (reset) begin
      outr_r       <= '0;
      fgo_r        <= {CHANNELS{1'b1}};
      wr_overrun_r <= {CHANNELS{1'b0}};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cpu_wr && ch_sel_s[i]) begin
          if (fgo_r[i]) begin
            outr_r[i] <= cpu_wdata;
            fgo_r[i]  <= 1'b0;
          end else begin
            wr_overrun_r[i] <= 1'b1;
          end
        end else if (!fgo_r[i] && out_ready[i]) begin
          fgo_r[i] <= 1'b1;
        end
      end
    end
  end

  // IEN and interrupt mask. int_ack beats ien_clr, which beats ien_set.
  always_ff @(posedge clock) begin
    if (reset) begin
      ien_r  <= 1'b0;
      mask_r <= {CHANNELS{1'b1}};
    end else begin
      if (int_ack) begin
        ien_r <= 1'b0;
      end else if (ien_clr) begin
        ien_r <= 1'b0;
      end else if (ien_set) begin
        ien_r <= 1'b1;
      end
      if (mask_wr) begin
        mask_r <= mask_wdata;
      end
    end
  end

  // R flip-flop and vector. The vector is latched only when R sets, so later
  // flag changes cannot alter it while the request is outstanding.
  always_ff @(posedge clock) begin
    if (reset) begin
      int_req_r <= 1'b0;
      int_vec_r <= {(CH_W+1){1'b0}};
    end else begin
      if (int_ack) begin
        int_req_r <= 1'b0;
      end else if (r_set_s) begin
        int_req_r <= 1'b1;
        int_vec_r <= win_s;
      end
    end
  end

  assign in_ready   = ~fgi_r;
  assign out_valid  = ~fgo_r;
  assign out_data   = outr_r;
  assign cpu_rdata  = inpr_r[cpu_ch];
  assign fgi        = fgi_r;
  assign fgo        = fgo_r;
  assign wr_overrun = wr_overrun_r;
  assign ien        = ien_r;
  assign int_req    = int_req_r;
  assign int_vec    = int_vec_r;

endmodule

// File: tb/tb_io_interrupt_unit.sv
// ---------------------------------------------------------------------------
// tb_io_interrupt_unit
//
// Directed bench for io_interrupt_unit (CH_W=2, DATA_W=8). Inputs change and
// outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_io_interrupt_unit;

  localparam int CH_W     = 2;
  localparam int DATA_W   = 8;
  localparam int CHANNELS = 4;

  logic                       clock;
  logic                       reset;
  logic [CHANNELS-1:0]        in_valid;
  logic [CHANNELS*DATA_W-1:0] in_data;
  logic [CHANNELS-1:0]        in_ready;
  logic [CHANNELS-1:0]        out_valid;
  logic [CHANNELS*DATA_W-1:0] out_data;
  logic [CHANNELS-1:0]        out_ready;
  logic [CH_W-1:0]            cpu_ch;
  logic                       cpu_rd;
  logic                       cpu_wr;
  logic [DATA_W-1:0]          cpu_wdata;
  logic [DATA_W-1:0]          cpu_rdata;
  logic [CHANNELS-1:0]        fgi;
  logic [CHANNELS-1:0]        fgo;
  logic [CHANNELS-1:0]        wr_overrun;
  logic                       ien_set;
  logic                       ien_clr;
  logic                       ien;
  logic                       mask_wr;
  logic [CHANNELS-1:0]        mask_wdata;
  logic                       fetch_idle;
  logic                       int_req;
  logic [CH_W:0]              int_vec;
  logic                       int_ack;

  int n_cmp = 0;
  int n_bad = 0;

  io_interrupt_unit #(.CH_W(CH_W), .DATA_W(DATA_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .cpu_ch     (cpu_ch),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .fgi        (fgi),
    .fgo        (fgo),
    .wr_overrun (wr_overrun),
    .ien_set    (ien_set),
    .ien_clr    (ien_clr),
    .ien        (ien),
    .mask_wr    (mask_wr),
    .mask_wdata (mask_wdata),
    .fetch_idle (fetch_idle),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_ack    (int_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; in_data = '0; out_ready = '0;
    cpu_ch = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = '0;
    ien_set = 1'b0; ien_clr = 1'b0; mask_wr = 1'b0; mask_wdata = '0;
    fetch_idle = 1'b0; int_ack = 1'b0;
    #2;
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_fgi",        64'(fgi),        64'h0);
    chk("rst_fgo",        64'(fgo),        64'hF);
    chk("rst_ien",        64'(ien),        64'h0);
    chk("rst_int_req",    64'(int_req),    64'h0);
    chk("rst_int_vec",    64'(int_vec),    64'h0);
    chk("rst_out_valid",  64'(out_valid),  64'h0);
    chk("rst_in_ready",   64'(in_ready),   64'hF);
    chk("rst_wr_overrun", 64'(wr_overrun), 64'h0);

    // Input handshake on channel 2
    in_valid = 4'b0100; in_data = 32'h0041_0000;
    tick();
    in_valid = 4'b0000;
    chk("in_fgi",      64'(fgi),      64'h4);
    chk("in_in_ready", 64'(in_ready), 64'hB);
    in_valid = 4'b0100; in_data = 32'h0042_0000;
    tick();
    in_valid = 4'b0000;
    chk("in_ignored_fgi", 64'(fgi), 64'h4);
    cpu_ch = 2'd2; cpu_rd = 1'b1;
    #1;
    chk("inp_rdata", 64'(cpu_rdata), 64'h41);
    tick();
    cpu_rd = 1'b0;
    chk("inp_fgi_clear", 64'(fgi), 64'h0);
    chk("inp_rdata_held", 64'(cpu_rdata), 64'h41);

    // Output handshake on channel 1
    cpu_ch = 2'd1; cpu_wr = 1'b1; cpu_wdata = 8'h5A;
    tick();
    cpu_wr = 1'b0;
    chk("out_fgo",       64'(fgo),            64'hD);
    chk("out_valid",     64'(out_valid),      64'h2);
    chk("out_data",      64'(out_data[15:8]), 64'h5A);
    chk("out_no_ovr",    64'(wr_overrun),     64'h0);
    cpu_wr = 1'b1; cpu_wdata = 8'h77;
    tick();
    cpu_wr = 1'b0;
    chk("ovr_flag",      64'(wr_overrun),     64'h2);
    chk("ovr_data_held", 64'(out_data[15:8]), 64'h5A);
    chk("ovr_fgo",       64'(fgo),            64'hD);
    out_ready = 4'b0010;
    tick();
    out_ready = 4'b0000;
    chk("xfer_fgo",      64'(fgo),        64'hF);
    chk("ovr_sticky",    64'(wr_overrun), 64'h2);

    // Priority: mask 1100, fgi[3]=1, fgo all 1 -> winner ch2 output = 3'b101
    mask_wr = 1'b1; mask_wdata = 4'b1100;
    in_valid = 4'b1000; in_data = 32'h3300_0000;
    tick();
    mask_wr = 1'b0; in_valid = 4'b0000;
    chk("pri_fgi", 64'(fgi), 64'h8);
    ien_set = 1'b1; fetch_idle = 1'b0;
    tick();
    ien_set = 1'b0;
    chk("pri_ien",         64'(ien),     64'h1);
    chk("pri_idle0_noreq", 64'(int_req), 64'h0);
    tick();
    chk("pri_idle0_still", 64'(int_req), 64'h0);
    fetch_idle = 1'b1;
    tick();
    chk("pri_req", 64'(int_req), 64'h1);
    chk("pri_vec", 64'(int_vec), 64'h5);
    // Clearing fgo[2] must not move the latched vector
    cpu_ch = 2'd2; cpu_wr = 1'b1; cpu_wdata = 8'hC3;
    tick();
    cpu_wr = 1'b0;
    chk("hold_fgo", 64'(fgo),     64'hB);
    chk("hold_vec", 64'(int_vec), 64'h5);
    chk("hold_req", 64'(int_req), 64'h1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("ack_req", 64'(int_req), 64'h0);
    chk("ack_ien", 64'(ien),     64'h0);
    tick();
    chk("ack_no_rereq", 64'(int_req), 64'h0);

    // Simultaneous controls
    ien_set = 1'b1; int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("set_ack_ien", 64'(ien), 64'h0);
    ien_clr = 1'b1;
    tick();
    ien_clr = 1'b0;
    chk("set_clr_ien", 64'(ien), 64'h0);
    tick();
    ien_set = 1'b0;
    chk("reset_ien", 64'(ien),     64'h1);
    chk("rereq_wait", 64'(int_req), 64'h0);
    tick();
    // fgo[2]=0 now, so ch3 input (3'b110) wins
    chk("rereq",     64'(int_req), 64'h1);
    chk("rereq_vec", 64'(int_vec), 64'h6);

    // Reset mid-operation
    chk("pre_rst_outr", 64'(out_data[23:16]), 64'hC3);
    reset = 1'b1; in_valid = 4'b0001; in_data = 32'h0000_00EE;
    tick();
    reset = 1'b0; in_valid = 4'b0000; cpu_ch = 2'd3;
    chk("mid_fgi",      64'(fgi),        64'h0);
    chk("mid_fgo",      64'(fgo),        64'hF);
    chk("mid_ien",      64'(ien),        64'h0);
    chk("mid_int_req",  64'(int_req),    64'h0);
    chk("mid_int_vec",  64'(int_vec),    64'h0);
    chk("mid_out_data", 64'(out_data),   64'h0);
    chk("mid_overrun",  64'(wr_overrun), 64'h0);
    chk("mid_rdata",    64'(cpu_rdata),  64'h0);
    // Mask returns to all ones: ch0 output (3'b001) wins
    ien_set = 1'b1;
    tick();
    ien_set = 1'b0;
    tick();
    chk("post_rst_req", 64'(int_req), 64'h1);
    chk("post_rst_vec", 64'(int_vec), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
